pci_intr_agg: RTL and testbench
===============================

# pci_intr_agg

Parametrised interrupt aggregator for the PCI function. It replaces the single-bit `intr_request` → `INT_N` flop with NUM_SRC synchronised interrupt sources and per-source edge/level mode, mask and write-1-to-clear status. It drives the PCI core's active-low `INT_N` input and sits in the `CLK`/`RST` domain supplied by the PCI core. A simple register port exposes its registers so the target bridge can map them into a BAR.

## Interface
Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..32.
- SYNC_STAGES, 2: synchroniser depth per source, ≥2.
- HOLDOFF_W, 16: width of the moderation holdoff counter (used only with INTR_MODERATION_EN).

Ports:
- CLK  in  1  PCI core clock; only clock of the block.
- RST  in  1  asynchronous, active-high reset.
- src  in  NUM_SRC  raw interrupt requests, asynchronous to CLK, active-high.
- reg_wr  in  1  write strobe, one cycle per access.
- reg_rd  in  1  read strobe, one cycle per access.
- reg_addr  in  3  register index.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- reg_rvalid  out  1  one-cycle pulse qualifying reg_rdata.
- INT_N  out  1  active-low interrupt to the PCI core, registered.

## Operation
- Each src bit passes through SYNC_STAGES flops, giving s. s feeds a history flop p. All of these reset to 0.
- MODE bit = 1 (edge): status bit sets when s & ~p.
- MODE bit = 0 (level): status bit sets every cycle s = 1.
- STATUS clears only by writing 1 to that bit.
- Set and clear on the same bit in the same cycle: set wins. A level source still high therefore stays pending.
- Register map (reg_addr):
  - 0: STATUS, read / write-1-to-clear.
  - 1: MASK, read/write, 1 = enabled.
  - 2: MODE, read/write.
  - 3: RAW, read-only s.
  - 4: HOLDOFF, read/write, HOLDOFF_W bits.
  - 5–7: reserved; read 0, writes ignored.
- Bits at or above NUM_SRC (or HOLDOFF_W) read 0 and ignore writes.
- reg_wr and reg_rd asserted together: the write is performed, and the read returns pre-write data.
- Interrupt condition: irq = |(STATUS & MASK). The next-cycle value of INT_N is ~irq, subject to moderation.
- Changing MODE leaves existing STATUS bits unchanged.

## Timing
- Reset values: reg_rdata = 0, reg_rvalid = 0, INT_N = 1. STATUS, MASK, MODE, HOLDOFF, sync chains, p and the holdoff counter are all 0.
- src rising edge to STATUS bit set: SYNC_STAGES+1 CLK edges. To INT_N low: SYNC_STAGES+2 edges.
- Register write takes effect on the edge that samples reg_wr.
- W1C of the last enabled pending bit: INT_N returns to 1 on the following edge.
- Read latency: reg_rvalid and reg_rdata are valid exactly one cycle after reg_rd. reg_rdata holds its value until the next read.
- Back-to-back reads on consecutive cycles are supported; no stalls.
- Writes always complete in the sampling cycle.
- src pulses shorter than one CLK period may be lost. This is a documented limitation.
- RST asserted mid-operation: all state clears immediately and INT_N = 1. After RST deasserts, a source held high re-triggers after the normal latency (p starts at 0).

## Configuration
- INTR_MODERATION_EN defined:
  - On every INT_N 0→1 transition, the counter loads HOLDOFF.
  - While the counter is nonzero, INT_N is forced to 1 and the counter decrements by 1 per cycle.
  - When the counter reaches 0 with irq = 1, INT_N drops on the next edge.
  - HOLDOFF = 0 means no holdoff.
  - Writing HOLDOFF does not reload an active count.
- INTR_MODERATION_EN undefined:
  - Counter logic is absent and address 4 behaves as reserved.
  - INT_N = ~irq registered, with no holdoff.

## Test plan
- Reset, then read all addresses → every reg_rdata = 0x00000000, reg_rvalid pulses once per read, INT_N = 1 throughout.
- NUM_SRC=8, MASK=0x01, MODE=0x01, pulse src[0] for 3 cycles → STATUS=0x01 after 3 edges, INT_N=0 after 4. Write STATUS 0x01 → INT_N=1 next edge and stays 1 (edge not re-seen).
- MODE=0x00, src[3] held high, MASK=0x08, write STATUS 0x08 → STATUS reads 0x08 again, INT_N stays 0. Drop src[3], then clear → INT_N=1.
- src[5] set with MASK=0 → STATUS=0x20, INT_N=1. Write MASK=0x20 → INT_N=0 one edge later.
- Same-cycle src[2] edge detection and W1C of bit 2 → bit 2 remains set.
- With INTR_MODERATION_EN, HOLDOFF=10, two sources pending, clear one then the other → INT_N high for exactly 10 cycles before reasserting on a new event. Assert RST mid-count → counter 0, INT_N=1.

Source files
------------

// File: rtl/pci_intr_agg.sv
// Interrupt aggregator: synchronised sources, per-source edge/level mode, mask, W1C status, active-low INT_N.
// Optional holdoff-based interrupt moderation is built when INTR_MODERATION_EN is defined.
module pci_intr_agg #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] src,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvalid,
  output logic               INT_N
);

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd4;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] p;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] set_bits;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] wdata_src;
  logic [DATA_W-1:0]  rd_mux;
  logic               irq;
  logic               wr_status;
  logic               wr_mask;
  logic               wr_mode;
  logic               unused_wdata;

`ifdef INTR_MODERATION_EN
  logic [HOLDOFF_W-1:0] holdoff;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic                 wr_holdoff;
`endif

  assign s            = sync_q[SYNC_STAGES-1];
  assign wdata_src    = reg_wdata[NUM_SRC-1:0];
  assign unused_wdata = ^reg_wdata;

  // Edge sources fire on a synchronised rising edge, level sources every cycle they are high
  assign set_bits = s & (~mode | ~p);
  assign irq      = |(status & mask);

  // Write decode and read mux; reads always see the pre-write register contents
  always_comb begin
    wr_status = 1'b0;
    wr_mask   = 1'b0;
    wr_mode   = 1'b0;
`ifdef INTR_MODERATION_EN
    wr_holdoff = 1'b0;
`endif
    rd_mux    = '0;
    if (reg_wr) begin
      case (reg_addr)
        ADDR_STATUS: wr_status = 1'b1;
        ADDR_MASK:   wr_mask   = 1'b1;
        ADDR_MODE:   wr_mode   = 1'b1;
`ifdef INTR_MODERATION_EN
        ADDR_HOLDOFF: wr_holdoff = 1'b1;
`endif
        default: ;
      endcase
    end
    case (reg_addr)
      ADDR_STATUS: rd_mux = DATA_W'(status);
      ADDR_MASK:   rd_mux = DATA_W'(mask);
      ADDR_MODE:   rd_mux = DATA_W'(mode);
      ADDR_RAW:    rd_mux = DATA_W'(s);
`ifdef INTR_MODERATION_EN
      ADDR_HOLDOFF: rd_mux = DATA_W'(holdoff);
`endif
      default:     rd_mux = '0;
    endcase
  end

  assign clr_bits = wr_status ? wdata_src : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q     <= '0;
      p          <= '0;
      status     <= '0;
      mask       <= '0;
      mode       <= '0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], src};
      p          <= s;
      // Set has priority so a still-asserted level source stays pending across a clear
      status     <= (status & ~clr_bits) | set_bits;
      if (wr_mask) mask <= wdata_src;
      if (wr_mode) mode <= wdata_src;
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_mux;
    end
  end

`ifdef INTR_MODERATION_EN
  // Holdoff reloads on each INT_N release; INT_N is held high for exactly HOLDOFF cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      holdoff  <= '0;
      hold_cnt <= '0;
      INT_N    <= 1'b1;
    end else begin
      if (wr_holdoff) holdoff <= reg_wdata[HOLDOFF_W-1:0];
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLDOFF_W'(1);
        INT_N    <= (hold_cnt == HOLDOFF_W'(1)) ? ~irq : 1'b1;
      end else begin
        INT_N <= ~irq;
        if (!INT_N && !irq) hold_cnt <= holdoff;
      end
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) INT_N <= 1'b1;
    else     INT_N <= ~irq;
  end
`endif

endmodule

// File: tb/tb_pci_intr_agg.sv
// Directed self-checking bench for pci_intr_agg (NUM_SRC=8, SYNC_STAGES=2, HOLDOFF_W=16).
module tb_pci_intr_agg;

  logic        CLK;
  logic        RST;
  logic [7:0]  src;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        INT_N;

  int tests_run    = 0;
  int tests_failed = 0;

  pci_intr_agg #(.NUM_SRC(8), .SYNC_STAGES(2), .HOLDOFF_W(16)) dut (
    .CLK(CLK), .RST(RST), .src(src), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .INT_N(INT_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    d = reg_rdata;
    v = reg_rvalid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    repeat (2) tick();
    tests_run++;
    if (INT_N !== 1'b1 || reg_rdata !== 32'h0 || reg_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got int_n=%b rdata=%h rvalid=%b want 1/00000000/0", INT_N, reg_rdata, reg_rvalid);
    end
    RST = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      reg_read(3'(a), d, v);
      tests_run++;
      if (d !== 32'h0 || v !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_read_%0d: got rdata=%h rvalid=%b want 00000000/1", a, d, v);
      end
      tick();
      tests_run++;
      if (reg_rvalid !== 1'b0 || INT_N !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_idle_%0d: got rvalid=%b int_n=%b want 0/1", a, reg_rvalid, INT_N);
      end
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic v;
    reg_write(3'd1, 32'h01);
    reg_write(3'd2, 32'h01);
    src[0] = 1'b1;
    tick();
    tick();
    tests_run++;
    if (INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_int_n_e2: got %b want 1", INT_N);
    end
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h0 || INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_status_e3: got status=%h int_n=%b want 00000000/1", d, INT_N);
    end
    src[0] = 1'b0;
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h1 || INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_status_e4: got status=%h int_n=%b want 00000001/0", d, INT_N);
    end
    reg_write(3'd0, 32'h01);
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL edge_w1c_same_edge: got %b want 0", INT_N);
    end
    tick();
    tests_run++;
    if (INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_w1c_release: got %b want 1", INT_N);
    end
    repeat (4) tick();
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h0 || INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL edge_no_retrigger: got status=%h int_n=%b want 00000000/1", d, INT_N);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    logic v;
    reg_write(3'd2, 32'h00);
    reg_write(3'd1, 32'h08);
    src[3] = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_assert: got %b want 0", INT_N);
    end
    reg_write(3'd0, 32'h08);
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h08 || INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_set_wins: got status=%h int_n=%b want 00000008/0", d, INT_N);
    end
    src[3] = 1'b0;
    repeat (3) tick();
    reg_write(3'd0, 32'h08);
    tick();
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h0 || INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL level_cleared: got status=%h int_n=%b want 00000000/1", d, INT_N);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    logic v;
    reg_write(3'd2, 32'h20);
    reg_write(3'd1, 32'h00);
    src[5] = 1'b1;
    repeat (5) tick();
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h20 || INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_pending_masked: got status=%h int_n=%b want 00000020/1", d, INT_N);
    end
    reg_read(3'd3, d, v);
    tests_run++;
    if (d !== 32'h20) begin
      tests_failed++;
      $display("FAIL mask_raw: got %h want 00000020", d);
    end
    reg_write(3'd1, 32'h20);
    tests_run++;
    if (INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_write_edge: got %b want 1", INT_N);
    end
    tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_enable: got %b want 0", INT_N);
    end
    reg_write(3'd0, 32'h20);
    tick();
    tests_run++;
    if (INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_clear: got %b want 1", INT_N);
    end
    src[5] = 1'b0;
    reg_write(3'd1, 32'h00);
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic v;
    reg_write(3'd2, 32'h04);
    reg_write(3'd1, 32'h04);
    src[2] = 1'b1;
    tick();
    tick();
    // W1C sampled on the same edge that captures the synchronised rising edge
    reg_write(3'd0, 32'h04);
    tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_int_n: got %b want 0", INT_N);
    end
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h04) begin
      tests_failed++;
      $display("FAIL same_cycle_status: got %h want 00000004", d);
    end
    reg_write(3'd0, 32'h04);
    src[2] = 1'b0;
    tick();
    tests_run++;
    if (INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_clear: got %b want 1", INT_N);
    end
    reg_write(3'd1, 32'h00);
    reg_write(3'd2, 32'h00);
  endtask

  task automatic test_reg_access();
    logic [31:0] d;
    logic v;
    reg_write(3'd1, 32'h04);
    reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 3'd1; reg_wdata = 32'h5A;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
    tests_run++;
    if (reg_rdata !== 32'h04 || reg_rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rw_same_cycle: got rdata=%h rvalid=%b want 00000004/1", reg_rdata, reg_rvalid);
    end
    reg_read(3'd1, d, v);
    tests_run++;
    if (d !== 32'h5A) begin
      tests_failed++;
      $display("FAIL rw_post_write: got %h want 0000005a", d);
    end
    reg_write(3'd1, 32'hFFFF_FFFF);
    reg_read(3'd1, d, v);
    tests_run++;
    if (d !== 32'hFF) begin
      tests_failed++;
      $display("FAIL mask_upper_bits: got %h want 000000ff", d);
    end
    reg_write(3'd1, 32'h00);
    reg_write(3'd5, 32'hDEAD_BEEF);
    reg_read(3'd5, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reserved_read: got %h want 00000000", d);
    end
    reg_write(3'd4, 32'h0001_2345);
    reg_read(3'd4, d, v);
    tests_run++;
`ifdef INTR_MODERATION_EN
    if (d !== 32'h2345) begin
      tests_failed++;
      $display("FAIL holdoff_rw: got %h want 00002345", d);
    end
`else
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL holdoff_reserved: got %h want 00000000", d);
    end
`endif
    reg_write(3'd4, 32'h0);
  endtask

  task automatic test_back_to_back();
    reg_write(3'd2, 32'hA5);
    reg_write(3'd1, 32'h3C);
    reg_rd = 1'b1; reg_addr = 3'd1;
    tick();
    tests_run++;
    if (reg_rdata !== 32'h3C || reg_rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: got rdata=%h rvalid=%b want 0000003c/1", reg_rdata, reg_rvalid);
    end
    reg_addr = 3'd2;
    tick();
    reg_rd = 1'b0;
    tests_run++;
    if (reg_rdata !== 32'hA5 || reg_rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second: got rdata=%h rvalid=%b want 000000a5/1", reg_rdata, reg_rvalid);
    end
    tick();
    tests_run++;
    if (reg_rdata !== 32'hA5 || reg_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got rdata=%h rvalid=%b want 000000a5/0", reg_rdata, reg_rvalid);
    end
    reg_write(3'd1, 32'h00);
    reg_write(3'd2, 32'h00);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    reg_write(3'd1, 32'h10);
    src[4] = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got %b want 0", INT_N);
    end
    #2 RST = 1'b1;
    #1;
    tests_run++;
    if (INT_N !== 1'b1 || reg_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got int_n=%b rvalid=%b want 1/0", INT_N, reg_rvalid);
    end
    tick();
    RST = 1'b0;
    reg_read(3'd1, d, v);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_mask: got %h want 00000000", d);
    end
    tick();
    tick();
    reg_read(3'd0, d, v);
    tests_run++;
    if (d !== 32'h10 || INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_retrigger: got status=%h int_n=%b want 00000010/1", d, INT_N);
    end
    reg_write(3'd1, 32'h10);
    tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_enable: got %b want 0", INT_N);
    end
    src[4] = 1'b0;
    repeat (3) tick();
    reg_write(3'd0, 32'h10);
    tick();
    tests_run++;
    if (INT_N !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_clear: got %b want 1", INT_N);
    end
    reg_write(3'd1, 32'h00);
  endtask

`ifdef INTR_MODERATION_EN
  task automatic test_moderation();
    int hi;
    reg_write(3'd4, 32'd10);
    reg_write(3'd2, 32'h03);
    reg_write(3'd1, 32'h03);
    src[1:0] = 2'b11;
    repeat (4) tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL mod_assert: got %b want 0", INT_N);
    end
    src[1:0] = 2'b00;
    repeat (3) tick();
    reg_write(3'd0, 32'h01);
    tick();
    tests_run++;
    if (INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL mod_one_left: got %b want 0", INT_N);
    end
    reg_write(3'd0, 32'h02);
    src[0] = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (INT_N === 1'b1) hi++;
      else break;
    end
    tests_run++;
    if (hi !== 10 || INT_N !== 1'b0) begin
      tests_failed++;
      $display("FAIL mod_holdoff_len: got %0d high cycles int_n=%b want 10/0", hi, INT_N);
    end
    src[0] = 1'b0;
    repeat (3) tick();
    reg_write(3'd0, 32'h01);
    repeat (3) tick();
    #2 RST = 1'b1;
    #1;
    tests_run++;
    if (INT_N !== 1'b1 || dut.hold_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL mod_rst_mid_count: got int_n=%b cnt=%0d want 1/0", INT_N, dut.hold_cnt);
    end
    tick();
    RST = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; src = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    test_reset();
    test_edge();
    test_level();
    test_mask();
    test_same_cycle();
    test_reg_access();
    test_back_to_back();
    test_reset_mid();
`ifdef INTR_MODERATION_EN
    test_moderation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
